// File: rtl/trig_capture_pkg.sv
// rtl/trig_capture_pkg.sv - shared constants and helpers for trig_capture
//   TRIG_N_DEFAULT  : default number of trigger lines
//   TRIG_CW_DEFAULT : default event-count width
//   sat_limit(cw)   : largest value a cw-bit counter may hold (2^cw - 1)
package trig_capture_pkg;

    localparam int TRIG_N_DEFAULT  = 16;
    localparam int TRIG_CW_DEFAULT = 16;

    function automatic longint unsigned sat_limit(input int cw);
        return (64'd1 << cw) - 64'd1;
    endfunction

endpackage

// File: rtl/trig_popcount.sv
// rtl/trig_popcount.sv - combinational population count
//   bits  [N-1:0]  : input vector
//   count [PW-1:0] : number of set bits in bits
module trig_popcount #(
    parameter int N  = 16,
    parameter int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [PW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/trig_capture.sv
// rtl/trig_capture.sv - sticky trigger-edge capture with snapshot-and-clear
//   clk1       : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   trig_in    : N trigger lines, rising edges are events
//   snap_req   : one-cycle request to snapshot live state and clear it
//   flags_out  : sticky flags at last snapshot
//   count_out  : saturating edge count at last snapshot
//   ovf_out    : repeat edge on an already-set flag since previous snapshot
//   snap_valid : one-cycle pulse when snapshot outputs update
//   pending    : registered OR of live flags
//   mask_in    : per-line event mask (only with TRIG_CAPTURE_MASK_EN)
module trig_capture
    import trig_capture_pkg::*;
#(
    parameter int N  = TRIG_N_DEFAULT,
    parameter int CW = TRIG_CW_DEFAULT
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic [N-1:0]  trig_in,
    input  logic          snap_req,
    output logic [N-1:0]  flags_out,
    output logic [CW-1:0] count_out,
    output logic          ovf_out,
    output logic          snap_valid,
    output logic          pending
`ifdef TRIG_CAPTURE_MASK_EN
    ,
    input  logic [N-1:0]  mask_in
`endif
);

    localparam int PW = $clog2(N + 1);
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] LIMIT = SW'(sat_limit(CW));

    logic [N-1:0]  trig_q;
    logic [N-1:0]  ev;
    logic [N-1:0]  live_flags;
    logic [N-1:0]  flags_next;
    logic [CW-1:0] live_count;
    logic [CW-1:0] count_next;
    logic          live_ovf;
    logic          ovf_next;
    logic [PW-1:0] ev_cnt;
    logic [SW-1:0] sum;

`ifdef TRIG_CAPTURE_MASK_EN
    assign ev = trig_in & ~trig_q & ~mask_in;
`else
    assign ev = trig_in & ~trig_q;
`endif

    trig_popcount #(
        .N  (N),
        .PW (PW)
    ) u_popcount (
        .bits  (ev),
        .count (ev_cnt)
    );

    // Next live values always fold in this cycle's events, so a snapshot
    // taken now includes them and the cleared state starts truly empty.
    always_comb begin
        sum        = SW'(live_count) + SW'(ev_cnt);
        count_next = (sum > LIMIT) ? LIMIT[CW-1:0] : sum[CW-1:0];
        flags_next = live_flags | ev;
        ovf_next   = live_ovf | (|(ev & live_flags));
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            // All ones: lines already high at release are not new edges.
            trig_q     <= '1;
            live_flags <= '0;
            live_count <= '0;
            live_ovf   <= 1'b0;
            flags_out  <= '0;
            count_out  <= '0;
            ovf_out    <= 1'b0;
            snap_valid <= 1'b0;
            pending    <= 1'b0;
        end else begin
            trig_q     <= trig_in;
            snap_valid <= snap_req;
            if (snap_req) begin
                flags_out  <= flags_next;
                count_out  <= count_next;
                ovf_out    <= ovf_next;
                live_flags <= '0;
                live_count <= '0;
                live_ovf   <= 1'b0;
                pending    <= 1'b0;
            end else begin
                live_flags <= flags_next;
                live_count <= count_next;
                live_ovf   <= ovf_next;
                pending    <= |flags_next;
            end
        end
    end

endmodule

// File: tb/tb_trig_capture.sv
// tb/tb_trig_capture.sv - directed self-checking bench for trig_capture
module tb_trig_capture;

    logic        clk1 = 1'b0;
    logic        reset;
    logic [15:0] trig_in;
    logic        snap_req;

    logic [15:0] flags_a;
    logic [15:0] count_a;
    logic        ovf_a;
    logic        valid_a;
    logic        pend_a;

    logic [15:0] flags_b;
    logic [3:0]  count_b;
    logic        ovf_b;
    logic        valid_b;
    logic        pend_b;

`ifdef TRIG_CAPTURE_MASK_EN
    logic [15:0] mask_in;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk1 = ~clk1;

    trig_capture #(.N(16), .CW(16)) dut_a (
        .clk1       (clk1),
        .reset      (reset),
        .trig_in    (trig_in),
        .snap_req   (snap_req),
        .flags_out  (flags_a),
        .count_out  (count_a),
        .ovf_out    (ovf_a),
        .snap_valid (valid_a),
        .pending    (pend_a)
`ifdef TRIG_CAPTURE_MASK_EN
        ,
        .mask_in    (mask_in)
`endif
    );

    trig_capture #(.N(16), .CW(4)) dut_b (
        .clk1       (clk1),
        .reset      (reset),
        .trig_in    (trig_in),
        .snap_req   (snap_req),
        .flags_out  (flags_b),
        .count_out  (count_b),
        .ovf_out    (ovf_b),
        .snap_valid (valid_b),
        .pending    (pend_b)
`ifdef TRIG_CAPTURE_MASK_EN
        ,
        .mask_in    (mask_in)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        trig_in  = 16'hFFFF;
        snap_req = 1'b0;
`ifdef TRIG_CAPTURE_MASK_EN
        mask_in  = 16'h0000;
`endif
        tick();
        tick();
        check("rst_flags", flags_a, 32'h0);
        check("rst_count", count_a, 32'h0);
        check("rst_ovf", ovf_a, 32'h0);
        check("rst_valid", valid_a, 32'h0);
        check("rst_pending", pend_a, 32'h0);

        // Lines held high through reset release produce no events
        #3 reset = 1'b0;
        tick();
        tick();
        check("hi_pending", pend_a, 32'h0);
        trig_in = 16'h0000;
        snap();
        check("hi_valid", valid_a, 32'h1);
        check("hi_flags", flags_a, 32'h0);
        check("hi_count", count_a, 32'h0);
        tick();
        check("hi_valid_drop", valid_a, 32'h0);

        // Edges on bits 0, 3, 15
        trig_in = 16'h8009;
        tick();
        check("t1_pending", pend_a, 32'h1);
        trig_in = 16'h0000;
        snap();
        check("t1_valid", valid_a, 32'h1);
        check("t1_flags", flags_a, 32'h8009);
        check("t1_count", count_a, 32'd3);
        check("t1_ovf", ovf_a, 32'h0);
        tick();
        check("t1_valid_pulse", valid_a, 32'h0);
        check("t1_hold_flags", flags_a, 32'h8009);
        check("t1_hold_count", count_a, 32'd3);
        check("t1_pending_clr", pend_a, 32'h0);

        // Three edges on bit 2
        for (int i = 0; i < 3; i++) begin
            trig_in = 16'h0004;
            tick();
            trig_in = 16'h0000;
            tick();
        end
        snap();
        check("t2_flags", flags_a, 32'h0004);
        check("t2_count", count_a, 32'd3);
        check("t2_ovf", ovf_a, 32'h1);

        // Edge coincident with snap_req
        trig_in  = 16'h0020;
        snap();
        check("t3_flags", flags_a, 32'h0020);
        check("t3_count", count_a, 32'd1);
        check("t3_ovf", ovf_a, 32'h0);
        check("t3_pending", pend_a, 32'h0);
        trig_in = 16'h0000;
        tick();
        snap();
        check("t3_empty_flags", flags_a, 32'h0);
        check("t3_empty_count", count_a, 32'h0);

        // Back-to-back snapshots
        trig_in  = 16'h0001;
        snap_req = 1'b1;
        tick();
        check("bb1_flags", flags_a, 32'h0001);
        check("bb1_count", count_a, 32'd1);
        trig_in = 16'h0003;
        tick();
        snap_req = 1'b0;
        check("bb2_valid", valid_a, 32'h1);
        check("bb2_flags", flags_a, 32'h0002);
        check("bb2_count", count_a, 32'd1);
        trig_in = 16'h0000;
        tick();

        // 20 single edges: CW=16 counts 20, CW=4 saturates at 15
        for (int i = 0; i < 20; i++) begin
            trig_in = 16'h0001;
            tick();
            trig_in = 16'h0000;
            tick();
        end
        snap();
        check("sat_a_count", count_a, 32'd20);
        check("sat_b_count", count_b, 32'hF);
        check("sat_b_flags", flags_b, 32'h0001);
        check("sat_b_ovf", ovf_b, 32'h1);

        // 16 simultaneous edges in one cycle
        trig_in = 16'hFFFF;
        tick();
        trig_in = 16'h0000;
        snap();
        check("wide_a_count", count_a, 32'd16);
        check("wide_a_flags", flags_a, 32'hFFFF);
        check("wide_a_ovf", ovf_a, 32'h0);
        check("wide_b_count", count_b, 32'hF);

        // Reset mid-operation discards live events and an in-flight snap_req
        trig_in = 16'h0010;
        tick();
        check("mid_pending", pend_a, 32'h1);
        snap_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_flags", flags_a, 32'h0);
        check("mid_rst_pending", pend_a, 32'h0);
        tick();
        snap_req = 1'b0;
        check("mid_rst_valid", valid_a, 32'h0);
        #2 reset = 1'b0;
        tick();
        snap();
        check("mid_after_flags", flags_a, 32'h0);
        check("mid_after_count", count_a, 32'h0);
        trig_in = 16'h0000;
        tick();

`ifdef TRIG_CAPTURE_MASK_EN
        mask_in = 16'h00FF;
        trig_in = 16'h0101;
        tick();
        trig_in = 16'h0000;
        snap();
        check("mask_flags", flags_a, 32'h0100);
        check("mask_count", count_a, 32'd1);
        mask_in = 16'h0000;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
